// File: rtl/block_rle_encoder_if.sv
// Coefficient-in / symbol-out stream bundle for the block run-length encoder.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface block_rle_encoder_if #(
  parameter int unsigned COEFF_W = 9
);
  logic signed [COEFF_W-1:0] coeff_in;
  logic                      coeff_valid;
  logic                      coeff_ready;
  logic [5:0]                run_out;
  logic signed [COEFF_W-1:0] level_out;
  logic                      eob_out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      block_done;

  modport slave (
    input  coeff_in, coeff_valid, out_ready,
    output coeff_ready, run_out, level_out, eob_out, out_valid, block_done
  );

  modport master (
    output coeff_in, coeff_valid, out_ready,
    input  coeff_ready, run_out, level_out, eob_out, out_valid, block_done
  );
endinterface

// File: rtl/block_rle_encoder.sv
// Zigzag-ordered 8x8 coefficient block to (run, level) symbols: DC, nonzero ACs, then EOB.
// Optional macro EOB_ELIDE_EN: drop the EOB when coefficient 63 is nonzero.
module block_rle_encoder #(
  parameter int unsigned COEFF_W = 9,
  parameter int unsigned BLK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  block_rle_encoder_if.slave bus
);

  localparam int unsigned       PosW    = $clog2(BLK_LEN);
  localparam logic [PosW-1:0]   LastPos = PosW'(BLK_LEN - 1);

  typedef enum logic [0:0] {StAccept, StEobPend} state_e;

  state_e                    state_q, state_d;
  logic [PosW-1:0]           pos_q, pos_d;
  logic [5:0]                zrun_q, zrun_d;
  logic [5:0]                run_q, run_d;
  logic signed [COEFF_W-1:0] level_q, level_d;
  logic                      eob_q, eob_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  // Marks the symbol whose handshake completes the block.
  logic                      final_q, final_d;

  logic out_free, xfer, hs, coeff_nz;

  assign out_free        = !valid_q || bus.out_ready;
  assign bus.coeff_ready = (state_q == StAccept) && out_free;
  assign xfer            = bus.coeff_valid && bus.coeff_ready;
  assign hs              = valid_q && bus.out_ready;
  assign coeff_nz        = |bus.coeff_in;

  assign bus.run_out    = run_q;
  assign bus.level_out  = level_q;
  assign bus.eob_out    = eob_q;
  assign bus.out_valid  = valid_q;
  assign bus.block_done = done_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    zrun_d  = zrun_q;
    run_d   = run_q;
    level_d = level_q;
    eob_d   = eob_q;
    final_d = final_q;
    valid_d = valid_q;
    if (hs) valid_d = 1'b0;
    done_d  = hs && final_q;

    case (state_q)
      StAccept: begin
        if (xfer) begin
          if (pos_q == '0) begin
            // DC is always emitted, even when zero.
            run_d   = '0;
            level_d = bus.coeff_in;
            eob_d   = 1'b0;
            final_d = 1'b0;
            valid_d = 1'b1;
          end else if (coeff_nz) begin
            run_d   = zrun_q;
            level_d = bus.coeff_in;
            eob_d   = 1'b0;
            final_d = 1'b0;
            valid_d = 1'b1;
            zrun_d  = '0;
          end else begin
            zrun_d = zrun_q + 6'd1;
          end

          if (pos_q == LastPos) begin
            pos_d  = '0;
            zrun_d = '0;
`ifdef EOB_ELIDE_EN
            if (coeff_nz) final_d = 1'b1;
            else          state_d = StEobPend;
`else
            state_d = StEobPend;
`endif
          end else begin
            pos_d = pos_q + PosW'(1);
          end
        end
      end
      StEobPend: begin
        if (out_free) begin
          run_d   = '0;
          level_d = '0;
          eob_d   = 1'b1;
          final_d = 1'b1;
          valid_d = 1'b1;
          state_d = StAccept;
        end
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccept;
      pos_q   <= '0;
      zrun_q  <= '0;
      run_q   <= '0;
      level_q <= '0;
      eob_q   <= 1'b0;
      final_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      zrun_q  <= zrun_d;
      run_q   <= run_d;
      level_q <= level_d;
      eob_q   <= eob_d;
      final_q <= final_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_block_rle_encoder.sv
// Scoreboard bench for block_rle_encoder: directed blocks push expected symbols,
// a negedge monitor pops and compares on every output handshake.
module tb_block_rle_encoder;

  typedef struct packed {
    logic [5:0]        run;
    logic signed [8:0] level;
    logic              eob;
    logic              last;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  block_rle_encoder_if #(.COEFF_W(9)) bus ();

  block_rle_encoder #(.COEFF_W(9), .BLK_LEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  sym_t              exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                sym_cnt = 0;
  int                done_cnt = 0;
  int                stall_cnt = 0;
  int                last_done_cyc = 0;
  int                done_gap = 0;
  logic signed [8:0] blk [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void exp_sym(input logic [5:0] run, input logic signed [8:0] level,
                                  input logic eob, input logic last);
    sym_t s;
    s.run = run; s.level = level; s.eob = eob; s.last = last;
    exp_q.push_back(s);
  endfunction

  // Drive at posedge+1; return at posedge+1 after the transfer edge.
  task automatic push(input logic signed [8:0] c);
    int n = 0;
    bus.coeff_in    = c;
    bus.coeff_valid = 1'b1;
    @(negedge clk);
    while (!bus.coeff_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("push_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int count, input logic release_valid);
    for (int i = 0; i < count; i++) push(blk[i]);
    if (release_valid) bus.coeff_valid = 1'b0;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: symbol scoreboard, hold stability, block_done timing.
  initial begin : monitor
    sym_t        e;
    logic        prev_stall   = 1'b0;
    logic        prev_hs_last = 1'b0;
    logic        exp_done;
    logic [15:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall   = 1'b0;
        prev_hs_last = 1'b0;
      end else begin
        exp_done     = prev_hs_last;
        prev_hs_last = 1'b0;
        if (bus.block_done || exp_done) check("block_done", 32'(bus.block_done), 32'(exp_done));
        if (bus.block_done) begin
          done_cnt++;
          done_gap      = cyc - last_done_cyc;
          last_done_cyc = cyc;
        end
        if (prev_stall)
          check("hold", {bus.out_valid, bus.run_out, bus.level_out, bus.eob_out}, {1'b1, held});
        if (bus.coeff_valid && !bus.coeff_ready) stall_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          sym_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_symbol: got run=%0d level=%0d eob=%0d, expected none",
                     bus.run_out, bus.level_out, bus.eob_out);
          end else begin
            e = exp_q.pop_front();
            check("symbol", {bus.run_out, bus.level_out, bus.eob_out}, {e.run, e.level, e.eob});
            prev_hs_last = e.last;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        held       = {bus.run_out, bus.level_out, bus.eob_out};
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, s0;
    rst_n           = 1'b0;
    bus.coeff_in    = '0;
    bus.coeff_valid = 1'b0;
    bus.out_ready   = 1'b1;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_symbol", {bus.run_out, bus.level_out, bus.eob_out}, 32'(0));
    check("rst_block_done", 32'(bus.block_done), 32'(0));
    check("rst_coeff_ready", 32'(bus.coeff_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero block.
    d0 = done_cnt; s0 = sym_cnt;
    clear_blk();
    exp_sym(6'd0, 9'sd0, 1'b0, 1'b0);
    exp_sym(6'd0, 9'sd0, 1'b1, 1'b1);
    send_block(64, 1'b1);
    drain();
    check("zero_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("zero_sym_cnt", 32'(sym_cnt - s0), 32'(2));

    // Sparse block.
    d0 = done_cnt; s0 = sym_cnt;
    clear_blk();
    blk[0] = -9'sd5; blk[1] = 9'sd3; blk[10] = -9'sd1;
    exp_sym(6'd0, -9'sd5, 1'b0, 1'b0);
    exp_sym(6'd0, 9'sd3, 1'b0, 1'b0);
    exp_sym(6'd8, -9'sd1, 1'b0, 1'b0);
    exp_sym(6'd0, 9'sd0, 1'b1, 1'b1);
    send_block(64, 1'b1);
    drain();
    check("sparse_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("sparse_sym_cnt", 32'(sym_cnt - s0), 32'(4));

    // Maximum run to coefficient 63.
    d0 = done_cnt; s0 = sym_cnt;
    clear_blk();
    blk[0] = 9'sd2; blk[63] = 9'sd7;
    exp_sym(6'd0, 9'sd2, 1'b0, 1'b0);
`ifdef EOB_ELIDE_EN
    exp_sym(6'd62, 9'sd7, 1'b0, 1'b1);
`else
    exp_sym(6'd62, 9'sd7, 1'b0, 1'b0);
    exp_sym(6'd0, 9'sd0, 1'b1, 1'b1);
`endif
    send_block(64, 1'b1);
    drain();
    check("maxrun_done_cnt", 32'(done_cnt - d0), 32'(1));
`ifdef EOB_ELIDE_EN
    check("maxrun_sym_cnt", 32'(sym_cnt - s0), 32'(2));
`else
    check("maxrun_sym_cnt", 32'(sym_cnt - s0), 32'(3));
`endif

    // Dense block with a 5-cycle downstream stall mid-block.
    d0 = done_cnt; s0 = sym_cnt;
    for (int i = 0; i < 64; i++) begin
      blk[i] = (i % 2 == 1) ? -9'(i + 1) : 9'(i + 1);
`ifdef EOB_ELIDE_EN
      exp_sym(6'd0, blk[i], 1'b0, i == 63);
`else
      exp_sym(6'd0, blk[i], 1'b0, 1'b0);
`endif
    end
`ifndef EOB_ELIDE_EN
    exp_sym(6'd0, 9'sd0, 1'b1, 1'b1);
`endif
    fork
      send_block(64, 1'b1);
      begin
        repeat (30) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_coeff_ready", 32'(bus.coeff_ready), 32'(0));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("dense_done_cnt", 32'(done_cnt - d0), 32'(1));
`ifdef EOB_ELIDE_EN
    check("dense_sym_cnt", 32'(sym_cnt - s0), 32'(64));
`else
    check("dense_sym_cnt", 32'(sym_cnt - s0), 32'(65));
`endif

    // Two back-to-back blocks, continuous valid.
    d0 = done_cnt;
    stall_cnt = 0;
    clear_blk();
    blk[0] = -9'sd5; blk[1] = 9'sd3; blk[10] = -9'sd1;
    for (int b = 0; b < 2; b++) begin
      exp_sym(6'd0, -9'sd5, 1'b0, 1'b0);
      exp_sym(6'd0, 9'sd3, 1'b0, 1'b0);
      exp_sym(6'd8, -9'sd1, 1'b0, 1'b0);
      exp_sym(6'd0, 9'sd0, 1'b1, 1'b1);
    end
    send_block(64, 1'b0);
    send_block(64, 1'b1);
    drain();
    check("b2b_stall_cycles", 32'(stall_cnt), 32'(1));
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'(2));
    check("b2b_done_gap", 32'(done_gap), 32'(65));

    // Reset at position 20 discards the partial block.
    d0 = done_cnt;
    clear_blk();
    blk[0] = 9'sd3; blk[5] = -9'sd2;
    exp_sym(6'd0, 9'sd3, 1'b0, 1'b0);
    exp_sym(6'd4, -9'sd2, 1'b0, 1'b0);
    send_block(20, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_reset_queue", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("mid_rst_symbol", {bus.run_out, bus.level_out, bus.eob_out}, 32'(0));
    check("mid_rst_block_done", 32'(bus.block_done), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_done_cnt", 32'(done_cnt - d0), 32'(0));
    @(posedge clk);
    #1;

    d0 = done_cnt; s0 = sym_cnt;
    clear_blk();
    blk[0] = 9'sd1;
    exp_sym(6'd0, 9'sd1, 1'b0, 1'b0);
    exp_sym(6'd0, 9'sd0, 1'b1, 1'b1);
    send_block(64, 1'b1);
    drain();
    check("after_rst_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("after_rst_sym_cnt", 32'(sym_cnt - s0), 32'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
